// File: rtl/sprite_line_scheduler.sv
// Per-line sprite Y-match scan controller with a ping-pong matched-index list.
// Optional macro SPRITE_OVERFLOW_DETECT_EN: full-table sweep with overflow flagging.
module sprite_line_scheduler #(
   parameter int NUM_SPRITES   = 512,
   parameter int MAX_PER_LINE  = 16,
   parameter int MATCH_LATENCY = 1,
   localparam int CW           = $clog2(MAX_PER_LINE) + 1
) (
   input  logic          clk_draw,
   input  logic          rst_draw,
   input  logic          line,
   input  logic [11:0]   next_sy,
   output logic [11:0]   match_sy,
   output logic [8:0]    sprite_index,
   input  logic          y_match,
   output logic          scan_busy,
   output logic          list_valid,
   input  logic          list_ready,
   output logic [8:0]    list_index,
   output logic          list_last,
   output logic [CW-1:0] list_count,
   output logic          line_overflow,
   output logic          scan_late
);

   localparam int AW = CW - 1;
   localparam logic [8:0]    LAST_IDX   = 9'(NUM_SPRITES - 1);
   localparam logic [CW-1:0] CAP        = CW'(MAX_PER_LINE);
   localparam logic [1:0]    DRAIN_LAST = 2'(MATCH_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t          state, state_next;
   logic            wr_bank;
   logic [CW-1:0]   wr_count;
   logic [CW-1:0]   rd_ptr;
   logic [1:0]      drain_cnt;
   logic [MATCH_LATENCY-1:0] pipe_valid;
   logic [8:0]      pipe_idx [MATCH_LATENCY];
   logic [8:0]      bank_mem [2*MAX_PER_LINE];
   logic            hit;
   logic            do_write;
`ifdef SPRITE_OVERFLOW_DETECT_EN
   logic            wr_ovf;
`endif

   // A line pulse flushes the pipeline, so the entry emerging on that edge is dropped.
   assign hit      = pipe_valid[MATCH_LATENCY-1] && y_match && !line;
   assign do_write = hit && (wr_count < CAP);

   always_ff @(posedge clk_draw or posedge rst_draw) begin
      if (rst_draw) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (line) begin
         state_next = SCAN;
      end else begin
         case (state)
            SCAN: begin
`ifdef SPRITE_OVERFLOW_DETECT_EN
               if (sprite_index == LAST_IDX) state_next = DRAIN;
`else
               // Once the list is full there is nothing left to collect.
               if (sprite_index == LAST_IDX || wr_count == CAP) state_next = DRAIN;
`endif
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_LAST) state_next = DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_draw or posedge rst_draw) begin
      if (rst_draw) begin
         wr_bank       <= 1'b0;
         wr_count      <= '0;
         rd_ptr        <= '0;
         drain_cnt     <= '0;
         pipe_valid    <= '0;
         for (int k = 0; k < MATCH_LATENCY; k++) pipe_idx[k] <= '0;
         match_sy      <= '0;
         sprite_index  <= '0;
         scan_busy     <= 1'b0;
         list_count    <= '0;
         line_overflow <= 1'b0;
         scan_late     <= 1'b0;
`ifdef SPRITE_OVERFLOW_DETECT_EN
         wr_ovf        <= 1'b0;
`endif
      end else begin
         pipe_valid[0] <= (state == SCAN);
         pipe_idx[0]   <= sprite_index;
         for (int k = 1; k < MATCH_LATENCY; k++) begin
            pipe_valid[k] <= pipe_valid[k-1];
            pipe_idx[k]   <= pipe_idx[k-1];
         end
         scan_busy <= (state_next == SCAN) || (state_next == DRAIN);

         if (line) begin
            wr_bank      <= ~wr_bank;
            list_count   <= wr_count;
            scan_late    <= (state == SCAN) || (state == DRAIN);
            rd_ptr       <= '0;
            match_sy     <= next_sy;
            wr_count     <= '0;
            sprite_index <= '0;
            drain_cnt    <= '0;
            pipe_valid   <= '0;
`ifdef SPRITE_OVERFLOW_DETECT_EN
            line_overflow <= wr_ovf;
            wr_ovf        <= 1'b0;
`endif
         end else begin
            if (state == SCAN && state_next == SCAN) sprite_index <= sprite_index + 9'd1;
            if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
            else                drain_cnt <= '0;
            if (do_write) wr_count <= wr_count + CW'(1);
`ifdef SPRITE_OVERFLOW_DETECT_EN
            if (hit && wr_count == CAP) wr_ovf <= 1'b1;
`endif
            if (list_valid && list_ready) rd_ptr <= rd_ptr + CW'(1);
         end
      end
   end

   // Bank RAM: write side addresses wr_bank, read side the opposite bank.
   always_ff @(posedge clk_draw) begin
      if (do_write) bank_mem[{wr_bank, wr_count[AW-1:0]}] <= pipe_idx[MATCH_LATENCY-1];
   end

   assign list_valid = (rd_ptr < list_count);
   assign list_index = list_valid ? bank_mem[{~wr_bank, rd_ptr[AW-1:0]}] : 9'd0;
   assign list_last  = list_valid && (rd_ptr == list_count - CW'(1));

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: directed line sequence, Y-match table model.
module tb_sprite_line_scheduler;

   localparam int NUM_SPRITES   = 512;
   localparam int MAX_PER_LINE  = 16;
   localparam int MATCH_LATENCY = 1;
   localparam int CW            = $clog2(MAX_PER_LINE) + 1;

   logic          clk_draw;
   logic          rst_draw;
   logic          line;
   logic [11:0]   next_sy;
   logic [11:0]   match_sy;
   logic [8:0]    sprite_index;
   logic          y_match;
   logic          scan_busy;
   logic          list_valid;
   logic          list_ready;
   logic [8:0]    list_index;
   logic          list_last;
   logic [CW-1:0] list_count;
   logic          line_overflow;
   logic          scan_late;

   logic [NUM_SPRITES-1:0] tbl;
   logic [8:0]  idx_pipe [MATCH_LATENCY];
   logic [9:0]  sb[$];
   logic [9:0]  pending[$];
   int          pend_count, hand_count;
   logic        pend_ovf, hand_ovf;
   int          total = 0;
   int          bad = 0;
   int          tick_count = 0;
   int          mark;
   logic [3:0]  ready_pat;

   sprite_line_scheduler #(
      .NUM_SPRITES(NUM_SPRITES),
      .MAX_PER_LINE(MAX_PER_LINE),
      .MATCH_LATENCY(MATCH_LATENCY)
   ) dut (
      .clk_draw(clk_draw),
      .rst_draw(rst_draw),
      .line(line),
      .next_sy(next_sy),
      .match_sy(match_sy),
      .sprite_index(sprite_index),
      .y_match(y_match),
      .scan_busy(scan_busy),
      .list_valid(list_valid),
      .list_ready(list_ready),
      .list_index(list_index),
      .list_last(list_last),
      .list_count(list_count),
      .line_overflow(line_overflow),
      .scan_late(scan_late)
   );

   initial clk_draw = 1'b0;
   always #5 clk_draw = ~clk_draw;

   // Y-compare model: answers for the index issued MATCH_LATENCY cycles ago.
   initial for (int k = 0; k < MATCH_LATENCY; k++) idx_pipe[k] = '0;
   always @(posedge clk_draw) begin
      idx_pipe[0] <= sprite_index;
      for (int k = 1; k < MATCH_LATENCY; k++) idx_pipe[k] <= idx_pipe[k-1];
   end
   assign y_match = tbl[idx_pipe[MATCH_LATENCY-1]];

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk_draw);
         tick_count++;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Expected list for the scan now running: ascending matches below limit, capped.
   task automatic buildExpected(input int limit);
      int n;
      int hits;
      logic [9:0] t;
      n = 0;
      hits = 0;
      pending.delete();
      for (int i = 0; i < limit; i++) begin
         if (tbl[i]) begin
            hits++;
            if (n < MAX_PER_LINE) begin
               pending.push_back({1'b0, 9'(i)});
               n++;
            end
         end
      end
      if (n > 0) begin
         t = pending.pop_back();
         pending.push_back(t | 10'h200);
      end
      pend_count = n;
`ifdef SPRITE_OVERFLOW_DETECT_EN
      pend_ovf = (hits > MAX_PER_LINE);
`else
      pend_ovf = 1'b0;
`endif
   endtask

   task automatic applyStimulus(input logic [11:0] sy);
      sb = pending;
      hand_count = pend_count;
      hand_ovf = pend_ovf;
      line = 1'b1;
      next_sy = sy;
      tick(1);
      line = 1'b0;
      next_sy = '0;
   endtask

   task automatic consumeList(input int budget);
      int c;
      logic [9:0] e;
      c = 0;
      while (sb.size() > 0 && c < budget) begin
         list_ready = ready_pat[c % 4];
         if (list_valid && list_ready) begin
            e = sb.pop_front();
            checkOutput("list_index", 32'(list_index), 32'(e[8:0]));
            checkOutput("list_last", 32'(list_last), 32'(e[9]));
         end
         tick(1);
         c++;
      end
      list_ready = 1'b0;
      checkOutput("sb_drained", sb.size(), 0);
      checkOutput("list_valid_after", 32'(list_valid), 0);
   endtask

   initial begin
      rst_draw = 1'b1;
      line = 1'b0;
      next_sy = '0;
      list_ready = 1'b0;
      tbl = '0;
      ready_pat = 4'b1111;
      pend_count = 0;
      pend_ovf = 1'b0;
      tick(3);
      rst_draw = 1'b0;

      for (int i = 0; i < 20; i++) begin
         tick(1);
         checkOutput("idle_list_valid", 32'(list_valid), 0);
      end
      checkOutput("rst_match_sy", 32'(match_sy), 0);
      checkOutput("rst_sprite_index", 32'(sprite_index), 0);
      checkOutput("rst_scan_busy", 32'(scan_busy), 0);
      checkOutput("rst_list_index", 32'(list_index), 0);
      checkOutput("rst_list_last", 32'(list_last), 0);
      checkOutput("rst_list_count", 32'(list_count), 0);
      checkOutput("rst_line_overflow", 32'(line_overflow), 0);
      checkOutput("rst_scan_late", 32'(scan_late), 0);

      // Line 1: three sparse matches including the last table entry.
      tbl[3] = 1'b1;
      tbl[40] = 1'b1;
      tbl[511] = 1'b1;
      applyStimulus(12'd100);
      buildExpected(NUM_SPRITES);
      checkOutput("l1_match_sy", 32'(match_sy), 100);
      checkOutput("l1_sprite_index", 32'(sprite_index), 0);
      checkOutput("l1_scan_busy", 32'(scan_busy), 1);
      checkOutput("l1_list_count", 32'(list_count), 0);
      checkOutput("l1_list_valid", 32'(list_valid), 0);
      tick(5);
      checkOutput("l1_index_step", 32'(sprite_index), 5);
      tick(507);
      checkOutput("l1_busy_last", 32'(scan_busy), 1);
      tick(1);
      checkOutput("l1_busy_fall", 32'(scan_busy), 0);
      checkOutput("l1_index_hold", 32'(sprite_index), 511);
      tick(80);

      // Line 2: hand over line 1, scan 20 consecutive matches.
      tbl = '0;
      for (int i = 10; i < 30; i++) tbl[i] = 1'b1;
      applyStimulus(12'd200);
      buildExpected(NUM_SPRITES);
      checkOutput("l2_match_sy", 32'(match_sy), 200);
      checkOutput("l2_list_count", 32'(list_count), 32'(hand_count));
      checkOutput("l2_scan_late", 32'(scan_late), 0);
      checkOutput("l2_overflow", 32'(line_overflow), 32'(hand_ovf));
      checkOutput("l2_list_valid", 32'(list_valid), 1);
      consumeList(20);
      tick(100);
`ifdef SPRITE_OVERFLOW_DETECT_EN
      checkOutput("l2_busy_full_sweep", 32'(scan_busy), 1);
`else
      checkOutput("l2_busy_early_stop", 32'(scan_busy), 0);
`endif
      tick(500);

      // Line 3: hand over the capped list with a stalling consumer.
      tbl = '0;
      tbl[5] = 1'b1;
      tbl[300] = 1'b1;
      applyStimulus(12'd300);
      buildExpected(200);
      mark = tick_count;
      checkOutput("l3_list_count", 32'(list_count), 32'(hand_count));
      checkOutput("l3_overflow", 32'(line_overflow), 32'(hand_ovf));
      checkOutput("l3_scan_late", 32'(scan_late), 0);
      ready_pat = 4'b1001;
      consumeList(80);
      ready_pat = 4'b1111;
      tick(199 - (tick_count - mark));

      // Line 4 arrives mid-scan: partial list with only index 5.
      tbl = '0;
      applyStimulus(12'd400);
      buildExpected(NUM_SPRITES);
      mark = tick_count;
      checkOutput("l4_scan_late", 32'(scan_late), 1);
      checkOutput("l4_list_count", 32'(list_count), 32'(hand_count));
      checkOutput("l4_sprite_index", 32'(sprite_index), 0);
      checkOutput("l4_match_sy", 32'(match_sy), 400);
      consumeList(10);
      checkOutput("l4_restart_index", 32'(sprite_index), tick_count - mark);
      tick(50 - (tick_count - mark));

      // Asynchronous reset mid-scan discards both banks.
      rst_draw = 1'b1;
      #1;
      checkOutput("mid_rst_busy", 32'(scan_busy), 0);
      checkOutput("mid_rst_index", 32'(sprite_index), 0);
      checkOutput("mid_rst_count", 32'(list_count), 0);
      checkOutput("mid_rst_valid", 32'(list_valid), 0);
      checkOutput("mid_rst_match_sy", 32'(match_sy), 0);
      tick(1);
      rst_draw = 1'b0;
      pending.delete();
      pend_count = 0;
      pend_ovf = 1'b0;
      tick(2);
      applyStimulus(12'd500);
      checkOutput("post_rst_count", 32'(list_count), 32'(hand_count));
      checkOutput("post_rst_valid", 32'(list_valid), 0);
      checkOutput("post_rst_late", 32'(scan_late), 0);
      checkOutput("post_rst_busy", 32'(scan_busy), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
